// File: rtl/mig_tt_eval_engine.sv
// Sequential MIG evaluator: sweeps all minterms through a loadable majority-node program.
// Latency TTW*(num_nodes+1)+1 from start to done; writes/starts are ignored while busy.
module mig_tt_eval_engine #(
  parameter  int NUM_INPUTS = 4,
  parameter  int MAX_NODES  = 16,
  localparam int TTW        = 1 << NUM_INPUTS,
  localparam int SELW       = $clog2(1 + NUM_INPUTS + MAX_NODES),
  localparam int AW         = $clog2(MAX_NODES),
  localparam int NW         = $clog2(MAX_NODES + 1),
  localparam int WW         = 3 * (SELW + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [WW-1:0]   wr_data,
  input  logic            start,
  input  logic [NW-1:0]   num_nodes,
  input  logic [SELW-1:0] out_sel,
  input  logic            out_inv,
  output logic            busy,
  output logic            done,
  output logic [TTW-1:0]  tt,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, EVAL, CAPTURE, FIN} state_t;

  state_t                state;
  logic [NUM_INPUTS-1:0] m;
  logic [AW-1:0]         k;
  logic [NW-1:0]         nn;
  logic [SELW-1:0]       osel;
  logic                  oinv;
  logic                  ovf;
  logic [MAX_NODES-1:0]  node_val;
  logic [WW-1:0]         prog [MAX_NODES];

  // A write coinciding with an accepted start is parked here so the run sees the old word.
  logic                  pend_vld;
  logic [AW-1:0]         pend_addr;
  logic [WW-1:0]         pend_data;

  // Returns {illegal, raw}; node operands are legal only below lim.
  function automatic logic [1:0] fetch(input logic [SELW-1:0]       s,
                                       input logic [NW-1:0]         lim,
                                       input logic [NUM_INPUTS-1:0] mt,
                                       input logic [MAX_NODES-1:0]  nv);
    logic raw;
    logic bad;
    raw = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (int'(s) == i + 1) raw = mt[i];
    for (int i = 0; i < MAX_NODES; i++)
      if (int'(s) == NUM_INPUTS + 1 + i) begin
        if (i < int'(lim)) raw = nv[i];
        else bad = 1'b1;
      end
    if (int'(s) > NUM_INPUTS + MAX_NODES) bad = 1'b1;
    return {bad, raw};
  endfunction

  logic [WW-1:0] word;
  logic [1:0]    fa, fb, fc, fo;
  logic          va, vb, vc, maj, bad_node;

  assign word = prog[k];

  always_comb begin
    fa       = fetch(word[WW-2 -: SELW], NW'(k), m, node_val);
    fb       = fetch(word[2*(SELW+1)-2 -: SELW], NW'(k), m, node_val);
    fc       = fetch(word[SELW-1:0], NW'(k), m, node_val);
    fo       = fetch(osel, nn, m, node_val);
    va       = fa[0] ^ word[WW-1];
    vb       = fb[0] ^ word[2*(SELW+1)-1];
    vc       = fc[0] ^ word[SELW];
    maj      = (va & vb) | (va & vc) | (vb & vc);
    bad_node = fa[1] | fb[1] | fc[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      tt        <= '0;
      err       <= 1'b0;
      m         <= '0;
      k         <= '0;
      nn        <= '0;
      osel      <= '0;
      oinv      <= 1'b0;
      ovf       <= 1'b0;
      node_val  <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      for (int i = 0; i < MAX_NODES; i++) prog[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en && start) begin
            pend_vld  <= 1'b1;
            pend_addr <= wr_addr;
            pend_data <= wr_data;
          end else if (wr_en) begin
            prog[wr_addr] <= wr_data;
          end
          if (start) begin
            busy     <= 1'b1;
            tt       <= '0;
            node_val <= '0;
            m        <= '0;
            k        <= '0;
            nn       <= num_nodes;
            osel     <= out_sel;
            oinv     <= out_inv;
            if (int'(num_nodes) > MAX_NODES) begin
              ovf   <= 1'b1;
              err   <= 1'b1;
              state <= EVAL;
            end else begin
              ovf   <= 1'b0;
              err   <= 1'b0;
              state <= (num_nodes == '0) ? CAPTURE : EVAL;
            end
          end
        end
        EVAL: begin
          if (ovf) begin
            state <= FIN;
          end else begin
            node_val[k] <= maj;
            if (bad_node) err <= 1'b1;
            if (NW'(k) == nn - NW'(1)) state <= CAPTURE;
            else k <= k + AW'(1);
          end
        end
        CAPTURE: begin
          tt[m] <= fo[0] ^ oinv;
          if (fo[1]) err <= 1'b1;
          k <= '0;
          if (m == NUM_INPUTS'(TTW - 1)) begin
            state <= FIN;
          end else begin
            m     <= m + NUM_INPUTS'(1);
            state <= (nn == '0) ? CAPTURE : EVAL;
          end
        end
        FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
          pend_vld <= 1'b0;
          if (pend_vld) prog[pend_addr] <= pend_data;
        end
      endcase
    end
  end

endmodule
